// File: rtl/mbldcm_pkg.sv
// Shared types and constants for the BLDC start/stop ramp sequencer.
package mbldcm_pkg;

  localparam int cDivWidth   = 32;
  localparam int cPhaseWidth = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DECEL = 3'd4
  } state_t;

endpackage

// File: rtl/mbldcm_ramp_sequencer_if.sv
// Command/status bundle between the bus register file and the ramp sequencer.
interface mbldcm_ramp_sequencer_if
  import mbldcm_pkg::*;
#(
  parameter int pDivWidth = cDivWidth
) ();

  logic                   iStart;
  logic                   iStopReq;
  logic [pDivWidth-1:0]   iStartDiv;
  logic [pDivWidth-1:0]   iTargetDiv;
  logic [pDivWidth-1:0]   iStepDiv;
  logic [15:0]            iStepInterval;
  logic [23:0]            iAlignCycles;
  logic [cPhaseWidth-1:0] iAlignPhase;

  logic [pDivWidth-1:0]   oDiv;
  logic                   oStop;
  logic [cPhaseWidth-1:0] oPhaseUpdate;
  logic                   oLatchPhaseUpdate;
  logic [2:0]             oState;
  logic                   oAtSpeed;
  logic                   oBusy;

  modport master (
    output iStart, iStopReq, iStartDiv, iTargetDiv, iStepDiv,
           iStepInterval, iAlignCycles, iAlignPhase,
    input  oDiv, oStop, oPhaseUpdate, oLatchPhaseUpdate, oState, oAtSpeed, oBusy
  );

  modport slave (
    input  iStart, iStopReq, iStartDiv, iTargetDiv, iStepDiv,
           iStepInterval, iAlignCycles, iAlignPhase,
    output oDiv, oStop, oPhaseUpdate, oLatchPhaseUpdate, oState, oAtSpeed, oBusy
  );

endinterface

// File: rtl/mbldcm_div_stepper.sv
// Combinational saturating move of a divider value one step toward a target.
module mbldcm_div_stepper
  import mbldcm_pkg::*;
#(
  parameter int pDivWidth = cDivWidth
) (
  input  logic [pDivWidth-1:0] i_current,
  input  logic [pDivWidth-1:0] i_target,
  input  logic [pDivWidth-1:0] i_step,
  output logic [pDivWidth-1:0] o_next,
  output logic                 o_reached
);

  logic                 w_rising;
  logic [pDivWidth-1:0] w_gap;
  logic                 w_saturate;

  // Comparing the step against the remaining gap clamps at the target and
  // keeps the add from wrapping, since the target never exceeds the max value.
  assign w_rising   = i_current < i_target;
  assign w_gap      = w_rising ? (i_target - i_current) : (i_current - i_target);
  assign w_saturate = i_step >= w_gap;
  assign o_next     = w_saturate ? i_target
                    : (w_rising ? (i_current + i_step) : (i_current - i_step));
  assign o_reached  = o_next == i_target;

endmodule

// File: rtl/mbldcm_ramp_sequencer.sv
// Align / ramp-up / run / ramp-down sequencer feeding the BLDC commutation core.
module mbldcm_ramp_sequencer
  import mbldcm_pkg::*;
#(
  parameter logic [3:0] pTotalPhaseStages = 4'd12,
  parameter int         pDivWidth         = cDivWidth
) (
  input logic                   iClock,
  input logic                   iReset,
  mbldcm_ramp_sequencer_if.slave bus
);

  state_t                 r_state;
  logic [pDivWidth-1:0]   r_div;
  logic [pDivWidth-1:0]   r_start_div;
  logic                   r_stop;
  logic [cPhaseWidth-1:0] r_phase;
  logic                   r_latch_phase;
  logic                   r_at_speed;
  logic [15:0]            r_int_cnt;
  logic [23:0]            r_align_cnt;

  logic [pDivWidth-1:0]   w_tgt_eff;
  logic [pDivWidth-1:0]   w_step_eff;
  logic [pDivWidth-1:0]   w_step_tgt;
  logic [pDivWidth-1:0]   w_next_div;
  logic                   w_reached;
  logic [cPhaseWidth-1:0] w_align_phase;

  assign w_tgt_eff     = (bus.iTargetDiv == '0) ? pDivWidth'(1) : bus.iTargetDiv;
  assign w_step_eff    = (bus.iStepDiv == '0) ? pDivWidth'(1) : bus.iStepDiv;
  assign w_step_tgt    = (r_state == ST_DECEL) ? r_start_div : w_tgt_eff;
  assign w_align_phase = (bus.iAlignPhase >= pTotalPhaseStages) ? '0 : bus.iAlignPhase;

  mbldcm_div_stepper #(.pDivWidth(pDivWidth)) u_stepper (
    .i_current (r_div),
    .i_target  (w_step_tgt),
    .i_step    (w_step_eff),
    .o_next    (w_next_div),
    .o_reached (w_reached)
  );

  // NOTE: every register here uses <= so all branches see the pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state       <= ST_IDLE;
      r_div         <= '0;
      r_start_div   <= '0;
      r_stop        <= 1'b1;
      r_phase       <= '0;
      r_latch_phase <= 1'b0;
      r_at_speed    <= 1'b0;
      r_int_cnt     <= '0;
      r_align_cnt   <= '0;
    end else begin
      r_latch_phase <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_stop <= 1'b1;
          if (bus.iStart && !bus.iStopReq) begin
            r_state       <= ST_ALIGN;
            r_div         <= bus.iStartDiv;
            r_start_div   <= bus.iStartDiv;
            r_phase       <= w_align_phase;
            r_latch_phase <= 1'b1;
            r_align_cnt   <= bus.iAlignCycles;
          end
        end
        ST_ALIGN: begin
          if (bus.iStopReq) begin
            r_state <= ST_IDLE;
          end else if (r_align_cnt == '0) begin
            r_state   <= ST_RAMP;
            r_stop    <= 1'b0;
            r_int_cnt <= bus.iStepInterval;
          end else begin
            r_align_cnt <= r_align_cnt - 24'd1;
          end
        end
        ST_RAMP: begin
          if (bus.iStopReq) begin
            r_state   <= ST_DECEL;
            r_int_cnt <= bus.iStepInterval;
          end else if (r_int_cnt == '0) begin
            r_int_cnt <= bus.iStepInterval;
            r_div     <= w_next_div;
            if (w_reached) begin
              r_state    <= ST_RUN;
              r_at_speed <= 1'b1;
            end
          end else begin
            r_int_cnt <= r_int_cnt - 16'd1;
          end
        end
        ST_RUN: begin
          // Stop outranks a live target change.
          if (bus.iStopReq) begin
            r_state    <= ST_DECEL;
            r_at_speed <= 1'b0;
            r_int_cnt  <= bus.iStepInterval;
          end else if (w_tgt_eff != r_div) begin
            r_state    <= ST_RAMP;
            r_at_speed <= 1'b0;
            r_int_cnt  <= bus.iStepInterval;
          end
        end
        ST_DECEL: begin
          r_at_speed <= 1'b0;
          if (r_int_cnt == '0) begin
            r_int_cnt <= bus.iStepInterval;
            r_div     <= w_next_div;
            if (w_reached) begin
              r_state <= ST_IDLE;
              r_stop  <= 1'b1;
            end
          end else begin
            r_int_cnt <= r_int_cnt - 16'd1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_stop     <= 1'b1;
          r_at_speed <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oDiv              = r_div;
  assign bus.oStop             = r_stop;
  assign bus.oPhaseUpdate      = r_phase;
  assign bus.oLatchPhaseUpdate = r_latch_phase;
  assign bus.oState            = r_state;
  assign bus.oAtSpeed          = r_at_speed;
  assign bus.oBusy             = r_state != ST_IDLE;

endmodule

// File: tb/tb_mbldcm_ramp_sequencer.sv
// Directed-vector bench for the ramp sequencer: align, ramp, retarget, decel, aborts, reset.
module tb_mbldcm_ramp_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mbldcm_ramp_sequencer_if #(.pDivWidth(32)) bus ();

  mbldcm_ramp_sequencer #(.pTotalPhaseStages(4'd12), .pDivWidth(32)) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_core(input string tag, input int st, input int dv, input int stp);
    check({tag, ".state"}, 32'(bus.oState), 32'(st));
    check({tag, ".div"},   bus.oDiv,        32'(dv));
    check({tag, ".stop"},  32'(bus.oStop),  32'(stp));
  endtask

  initial begin
    int exp_div;
    bus.iStart = 0; bus.iStopReq = 0;
    bus.iStartDiv = 0; bus.iTargetDiv = 0; bus.iStepDiv = 0;
    bus.iStepInterval = 0; bus.iAlignCycles = 0; bus.iAlignPhase = 0;
    tick(); tick();
    check_core("rst", 0, 0, 1);
    check("rst.busy",  32'(bus.oBusy), 0);
    check("rst.speed", 32'(bus.oAtSpeed), 0);
    check("rst.latch", 32'(bus.oLatchPhaseUpdate), 0);
    rst = 1'b0;
    tick();

    // Spin-up: 100 -> 40 in steps of 20, two clocks per step, three-cycle align.
    bus.iStartDiv = 100; bus.iTargetDiv = 40; bus.iStepDiv = 20;
    bus.iStepInterval = 1; bus.iAlignCycles = 2; bus.iAlignPhase = 5;
    bus.iStart = 1;
    tick();
    bus.iStart = 0;
    check_core("al0", 1, 100, 1);
    check("al0.latch", 32'(bus.oLatchPhaseUpdate), 1);
    check("al0.phase", 32'(bus.oPhaseUpdate), 5);
    check("al0.busy",  32'(bus.oBusy), 1);
    tick();
    check_core("al1", 1, 100, 1);
    check("al1.latch", 32'(bus.oLatchPhaseUpdate), 0);
    tick();
    check_core("al2", 1, 100, 1);
    tick();
    check_core("rp0", 2, 100, 0);
    tick(); check_core("rp1", 2, 100, 0);
    tick(); check_core("rp2", 2, 80, 0);
    tick(); check_core("rp3", 2, 80, 0);
    tick(); check_core("rp4", 2, 60, 0);
    check("rp4.speed", 32'(bus.oAtSpeed), 0);
    tick(); check_core("rp5", 2, 60, 0);
    tick(); check_core("run", 3, 40, 0);
    check("run.speed", 32'(bus.oAtSpeed), 1);
    tick(); check_core("run.hold", 3, 40, 0);

    // Live retarget upward while running.
    bus.iTargetDiv = 55; bus.iStepDiv = 10; bus.iStepInterval = 0;
    tick(); check_core("rt0", 2, 40, 0);
    check("rt0.speed", 32'(bus.oAtSpeed), 0);
    tick(); check_core("rt1", 2, 50, 0);
    tick(); check_core("rt2", 3, 55, 0);
    check("rt2.speed", 32'(bus.oAtSpeed), 1);

    // Stop request from RUN: climb back to the latched start divider 100.
    bus.iStopReq = 1;
    tick(); check_core("dc0", 4, 55, 0);
    check("dc0.speed", 32'(bus.oAtSpeed), 0);
    bus.iStopReq = 0;
    exp_div = 55;
    for (int i = 0; i < 4; i++) begin
      exp_div += 10;
      tick(); check_core($sformatf("dc%0d", i + 1), 4, exp_div, 0);
    end
    tick(); check_core("dc.end", 0, 100, 1);
    check("dc.busy", 32'(bus.oBusy), 0);

    // Start and stop together: stop wins.
    bus.iStart = 1; bus.iStopReq = 1;
    tick(); check_core("both", 0, 100, 1);
    check("both.latch", 32'(bus.oLatchPhaseUpdate), 0);

    // Out-of-range align phase, then abort during ALIGN.
    bus.iStopReq = 0; bus.iAlignPhase = 13; bus.iAlignCycles = 5; bus.iStartDiv = 90;
    tick();
    bus.iStart = 0;
    check_core("ph13", 1, 90, 1);
    check("ph13.phase", 32'(bus.oPhaseUpdate), 0);
    check("ph13.latch", 32'(bus.oLatchPhaseUpdate), 1);
    bus.iStopReq = 1;
    tick(); check_core("abort", 0, 90, 1);
    bus.iStopReq = 0;
    tick(); check_core("abort.idle", 0, 90, 1);

    // Zero target and zero step are treated as 1.
    bus.iStartDiv = 3; bus.iTargetDiv = 0; bus.iStepDiv = 0;
    bus.iStepInterval = 0; bus.iAlignCycles = 0; bus.iAlignPhase = 2;
    bus.iStart = 1;
    tick();
    bus.iStart = 0;
    check_core("z.al", 1, 3, 1);
    tick(); check_core("z.rp0", 2, 3, 0);
    tick(); check_core("z.rp1", 2, 2, 0);
    tick(); check_core("z.run", 3, 1, 0);
    check("z.speed", 32'(bus.oAtSpeed), 1);

    // Async reset in RUN, then async reset mid-RAMP with oDiv at 70.
    rst = 1'b1; #1;
    check_core("rst.run", 0, 0, 1);
    rst = 1'b0;
    tick();
    bus.iStartDiv = 100; bus.iTargetDiv = 40; bus.iStepDiv = 30;
    bus.iStepInterval = 0; bus.iAlignCycles = 0;
    bus.iStart = 1;
    tick();
    bus.iStart = 0;
    tick(); check_core("m.rp0", 2, 100, 0);
    tick(); check_core("m.rp1", 2, 70, 0);
    #2;
    rst = 1'b1; #1;
    check_core("m.rst", 0, 0, 1);
    check("m.rst.busy",  32'(bus.oBusy), 0);
    check("m.rst.speed", 32'(bus.oAtSpeed), 0);
    rst = 1'b0;
    tick(); check_core("m.idle", 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
